// File: rtl/pc_gen_if.sv
// Fetch-side bundle between EX-stage redirect resolution and the PC generator.
// The generator uses the slave view; the requester/observer uses the master view.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              trap;
  logic              jr_en;
  logic [ADDR_W-1:0] jr_target;
  logic              jump_en;
  logic [25:0]       jump_addr;
  logic              br_en;
  logic [15:0]       br_off;
  logic [ADDR_W-1:0] ex_pc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fetch_valid;
  logic              halted;
  logic              redirect;

  modport master (
    output stall, trap, jr_en, jr_target, jump_en, jump_addr, br_en, br_off, ex_pc,
    input  pc, pc_plus4, fetch_valid, halted, redirect
  );

  modport slave (
    input  stall, trap, jr_en, jr_target, jump_en, jump_addr, br_en, br_off, ex_pc,
    output pc, pc_plus4, fetch_valid, halted, redirect
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Program-counter generator: sequential +4, branch/jump/jr/trap redirects with zero-bubble apply,
// a one-entry pending-redirect buffer while stalled, and halt after fetching LAST_PC.
module pc_gen_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 'h0000_3000,
  parameter logic [ADDR_W-1:0] LAST_PC      = 'h0000_307C,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 'h0000_4180
) (
  input logic    clk,
  input logic    PcReSet_n,
  pc_gen_if.slave bus
);
  localparam logic [2:0] PRIO_NONE = 3'd0;
  localparam logic [2:0] PRIO_BR   = 3'd1;
  localparam logic [2:0] PRIO_J    = 3'd2;
  localparam logic [2:0] PRIO_JR   = 3'd3;
  localparam logic [2:0] PRIO_TRAP = 3'd4;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [2:0]        pend_prio_q, pend_prio_d;
  logic              pend_vld_q, pend_vld_d;
  logic              halted_q, halted_d;
  logic              redir_q, redir_d;

  logic [ADDR_W-1:0] ex_seq, br_tgt, j_tgt, jr_tgt;
  logic [ADDR_W-1:0] fresh_tgt;
  logic [2:0]        fresh_prio;
  logic              fresh_wins;

  assign ex_seq = bus.ex_pc + ADDR_W'(4);
  assign br_tgt = ex_seq + {{(ADDR_W-18){bus.br_off[15]}}, bus.br_off, 2'b00};
  assign j_tgt  = {ex_seq[ADDR_W-1:28], bus.jump_addr, 2'b00};
  assign jr_tgt = bus.jr_target & ~ADDR_W'(3);

  always_comb begin
    fresh_prio = PRIO_NONE;
    fresh_tgt  = '0;
    if (bus.trap) begin
      fresh_prio = PRIO_TRAP;
      fresh_tgt  = TRAP_VECTOR;
    end else if (bus.jr_en) begin
      fresh_prio = PRIO_JR;
      fresh_tgt  = jr_tgt;
    end else if (bus.jump_en) begin
      fresh_prio = PRIO_J;
      fresh_tgt  = j_tgt;
    end else if (bus.br_en) begin
      fresh_prio = PRIO_BR;
      fresh_tgt  = br_tgt;
    end
  end

  // Ties with the buffered entry go to the fresh request (it is the newer decision).
  assign fresh_wins = (fresh_prio != PRIO_NONE) && (!pend_vld_q || fresh_prio >= pend_prio_q);

  always_comb begin
    pc_d        = pc_q;
    pend_tgt_d  = pend_tgt_q;
    pend_prio_d = pend_prio_q;
    pend_vld_d  = pend_vld_q;
    halted_d    = halted_q;
    redir_d     = 1'b0;
    if (bus.stall) begin
      if (fresh_prio != PRIO_NONE && (!pend_vld_q || fresh_prio > pend_prio_q)) begin
        pend_vld_d  = 1'b1;
        pend_prio_d = fresh_prio;
        pend_tgt_d  = fresh_tgt;
      end
    end else if (fresh_wins || pend_vld_q) begin
      pc_d        = fresh_wins ? fresh_tgt : pend_tgt_q;
      pend_vld_d  = 1'b0;
      pend_prio_d = PRIO_NONE;
      halted_d    = 1'b0;
      redir_d     = 1'b1;
    end else if (pc_q == LAST_PC) begin
      halted_d = 1'b1;
    end else begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge PcReSet_n) begin
    if (!PcReSet_n) begin
      pc_q        <= RESET_VECTOR;
      pend_tgt_q  <= '0;
      pend_prio_q <= PRIO_NONE;
      pend_vld_q  <= 1'b0;
      halted_q    <= 1'b0;
      redir_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_prio_q <= pend_prio_d;
      pend_vld_q  <= pend_vld_d;
      halted_q    <= halted_d;
      redir_q     <= redir_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + ADDR_W'(4);
  assign bus.fetch_valid = !halted_q;
  assign bus.halted      = halted_q;
  assign bus.redirect    = redir_q;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed scenarios followed by randomized traffic, checked against a request-level reference model.
module tb_pc_gen_unit;
  localparam logic [31:0] RV   = 32'h0000_3000;
  localparam logic [31:0] LAST = 32'h0000_307C;
  localparam logic [31:0] TV   = 32'h0000_4180;

  logic clk = 1'b0;
  logic PcReSet_n;
  int   checks = 0;
  int   errors = 0;

  pc_gen_if #(.ADDR_W(32)) bus ();

  pc_gen_unit dut (
    .clk       (clk),
    .PcReSet_n (PcReSet_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state: where fetch is, whether it is exhausted, and the remembered redirect.
  logic [31:0] m_pc;
  logic        m_halt, m_redir;
  int          m_pend_rank;
  logic [31:0] m_pend_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},          bus.pc, m_pc);
    chk({tag, ".pc_plus4"},    bus.pc_plus4, m_pc + 32'd4);
    chk({tag, ".halted"},      32'(bus.halted), 32'(m_halt));
    chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(!m_halt));
    chk({tag, ".redirect"},    32'(bus.redirect), 32'(m_redir));
  endtask

  function automatic int req_rank();
    if (bus.trap)    return 4;
    if (bus.jr_en)   return 3;
    if (bus.jump_en) return 2;
    if (bus.br_en)   return 1;
    return 0;
  endfunction

  function automatic logic [31:0] req_target(input int rank);
    logic [31:0] link;
    link = bus.ex_pc + 32'd4;
    case (rank)
      4:       return TV;
      3:       return bus.jr_target - (bus.jr_target % 4);
      2:       return (link & 32'hF000_0000) + {4'h0, bus.jump_addr, 2'b00};
      default: return link + 32'(int'($signed(bus.br_off)) * 4);
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RV; m_halt = 1'b0; m_redir = 1'b0; m_pend_rank = 0; m_pend_tgt = '0;
  endtask

  // One clock edge: predict from the inputs presented, let the edge happen, then compare.
  task automatic tick(input string tag);
    int          r;
    logic [31:0] t;
    r = req_rank();
    t = (r != 0) ? req_target(r) : 32'h0;
    if (bus.stall) begin
      m_redir = 1'b0;
      if (r > m_pend_rank) begin
        m_pend_rank = r; m_pend_tgt = t;
      end
    end else if (r != 0 || m_pend_rank != 0) begin
      m_pc = (r != 0 && r >= m_pend_rank) ? t : m_pend_tgt;
      m_pend_rank = 0; m_halt = 1'b0; m_redir = 1'b1;
    end else begin
      m_redir = 1'b0;
      if (m_pc == LAST) m_halt = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle();
    bus.stall = 0; bus.trap = 0; bus.jr_en = 0; bus.jump_en = 0; bus.br_en = 0;
  endtask

  initial begin
    PcReSet_n = 1'b0;
    idle();
    bus.jr_target = '0; bus.jump_addr = '0; bus.br_off = '0; bus.ex_pc = '0;
    model_reset();
    #12;
    chk("reset.pc", bus.pc, RV);
    chk("reset.redirect", 32'(bus.redirect), 32'h0);
    chk("reset.halted", 32'(bus.halted), 32'h0);
    @(negedge clk);
    PcReSet_n = 1'b1;
    #1;
    chk("rel.fetch_valid", 32'(bus.fetch_valid), 32'h1);

    // Sequential stepping after reset
    for (int i = 0; i < 4; i++) tick("seq");
    chk("seq.pc3010", bus.pc, 32'h0000_3010);

    // Backward branch
    bus.br_en = 1; bus.ex_pc = 32'h3008; bus.br_off = 16'hFFFE;
    tick("br");
    chk("br.pc3004", bus.pc, 32'h0000_3004);
    chk("br.pulse", 32'(bus.redirect), 32'h1);
    idle();
    tick("br.after");
    chk("br.pulse_end", 32'(bus.redirect), 32'h0);

    // Stalled branch then higher-priority jr replaces it in the buffer
    bus.stall = 1; bus.br_en = 1; bus.ex_pc = 32'h3038; bus.br_off = 16'h0001;
    tick("st.br");
    bus.br_en = 0; bus.jr_en = 1; bus.jr_target = 32'h3103;
    tick("st.jr");
    idle();
    tick("st.rel");
    chk("st.pc3100", bus.pc, 32'h0000_3100);

    // Buffered jump loses to a fresh trap on release; buffer empty afterwards
    bus.stall = 1; bus.jump_en = 1; bus.ex_pc = 32'h3070; bus.jump_addr = 26'h0000_800;
    tick("tr.jbuf");
    idle(); bus.trap = 1;
    tick("tr.rel");
    chk("tr.pc4180", bus.pc, TV);
    idle();
    tick("tr.empty");
    chk("tr.seq", bus.pc, 32'h0000_4184);

    // Run to the end of imem, halt, then leave via jump
    bus.jr_en = 1; bus.jr_target = 32'h3070;
    tick("h.jr");
    idle();
    for (int i = 0; i < 5; i++) tick("h.seq");
    chk("h.pc", bus.pc, LAST);
    chk("h.halted", 32'(bus.halted), 32'h1);
    chk("h.fv", 32'(bus.fetch_valid), 32'h0);
    bus.jump_en = 1; bus.ex_pc = 32'h3070; bus.jump_addr = 26'h0000C00;
    tick("h.j");
    chk("h.jpc", bus.pc, 32'h0000_3000);
    chk("h.unhalt", 32'(bus.halted), 32'h0);
    idle();

    // Wrap-around of sequential fetch above LAST_PC
    bus.jr_en = 1; bus.jr_target = 32'hFFFF_FFFC;
    tick("w.jr");
    idle();
    tick("w.seq");
    chk("w.pc0", bus.pc, 32'h0);

    // Asynchronous reset while a redirect is buffered
    bus.stall = 1; bus.br_en = 1; bus.ex_pc = 32'h5000; bus.br_off = 16'h0010;
    tick("ar.buf");
    #3;
    PcReSet_n = 1'b0;
    #1;
    model_reset();
    chk("ar.pc", bus.pc, RV);
    chk("ar.redirect", 32'(bus.redirect), 32'h0);
    #2;
    idle();
    PcReSet_n = 1'b1;
    tick("ar.rel");
    chk("ar.pc3004", bus.pc, 32'h0000_3004);

    // Randomized traffic, biased so halting and wrap-around both occur
    for (int i = 0; i < 600; i++) begin
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.trap      = ($urandom_range(0, 40) == 0);
      bus.jr_en     = ($urandom_range(0, 12) == 0);
      bus.jump_en   = ($urandom_range(0, 12) == 0);
      bus.br_en     = ($urandom_range(0, 8) == 0);
      case ($urandom_range(0, 3))
        0:       bus.jr_target = $urandom;
        1:       bus.jr_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: bus.jr_target = 32'h3060 + 32'($urandom_range(0, 35));
      endcase
      bus.ex_pc     = ($urandom_range(0, 1) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 255));
      bus.jump_addr = 26'($urandom);
      bus.br_off    = 16'($urandom);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
